// File: rtl/qam_demap_out_buffer.sv
// Collects one burst of demapped symbols and drains it as MSB-first packed words.
// Output word 0 is valid the cycle after the last symbol; dout holds under back-pressure; din_ready is low while draining.
module qam_demap_out_buffer #(
    parameter int SYM_BITS       = 4,
    parameter int ACTIVE_SUBCARR = 28,
    parameter int SYMBOL_NUM     = 8,
    parameter int OUT_BITS       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SYM_BITS-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic                tx_done,
    output logic [OUT_BITS-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                buff_full,
    output logic                frame_done,
    output logic                overflow_err
);
    localparam int FRAME_SYMS  = ACTIVE_SUBCARR * SYMBOL_NUM;
    localparam int FRAME_BITS  = FRAME_SYMS * SYM_BITS;
    localparam int FRAME_WORDS = FRAME_BITS / OUT_BITS;
    localparam int SYM_CW      = $clog2(FRAME_SYMS + 1);
    localparam int WORD_CW     = $clog2(FRAME_WORDS + 1);

    if (FRAME_BITS % OUT_BITS != 0) begin : g_bad_cfg
        $error("frame bit count must be a multiple of OUT_BITS");
    end

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] buf_q, buf_d;
    logic [SYM_CW-1:0]     sym_cnt_q, sym_cnt_d;
    logic [WORD_CW-1:0]    word_cnt_q, word_cnt_d;
    logic                  frame_done_q, frame_done_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        sym_cnt_d    = sym_cnt_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;
        // Abort wins over any handshake on the same edge.
        if (tx_done) begin
            state_d    = FILL;
            buf_d      = '0;
            sym_cnt_d  = '0;
            word_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (din_valid && state_q == DRAIN) begin
                ovf_d = 1'b1;
            end
            unique case (state_q)
                FILL: begin
                    if (din_valid) begin
                        buf_d = (buf_q << SYM_BITS) | FRAME_BITS'(din);
                        if (sym_cnt_q == SYM_CW'(FRAME_SYMS - 1)) begin
                            state_d   = DRAIN;
                            sym_cnt_d = '0;
                        end else begin
                            sym_cnt_d = sym_cnt_q + SYM_CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (dout_ready) begin
                        buf_d = buf_q << OUT_BITS;
                        if (word_cnt_q == WORD_CW'(FRAME_WORDS - 1)) begin
                            state_d      = FILL;
                            word_cnt_d   = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + WORD_CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            buf_q        <= '0;
            sym_cnt_q    <= '0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            sym_cnt_q    <= sym_cnt_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign din_ready    = (state_q == FILL);
    assign dout_valid   = (state_q == DRAIN);
    assign buff_full    = dout_valid;
    assign dout         = dout_valid ? buf_q[FRAME_BITS-1 -: OUT_BITS] : '0;
    assign frame_done   = frame_done_q;
    assign overflow_err = ovf_q;
endmodule

// File: tb/tb_qam_demap_out_buffer.sv
// Randomized bench for the demapper output buffer against a symbol/bit-queue reference model.
module tb_qam_demap_out_buffer;
    localparam int SB = 4;
    localparam int OB = 8;
    localparam int FS = 28 * 8;
    localparam int FW = FS * SB / OB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0, din_valid = 1'b0, tx_done = 1'b0, dout_ready = 1'b0;
    logic [SB-1:0] din = '0;
    logic          din_ready, dout_valid, buff_full, frame_done, overflow_err;
    logic [OB-1:0] dout;

    logic       b_rst_n = 1'b0, b_din_valid = 1'b0, b_tx_done = 1'b0, b_dout_ready = 1'b0;
    logic [5:0] b_din = '0;
    logic       b_din_ready, b_dout_valid, b_buff_full, b_frame_done, b_overflow_err;
    logic [7:0] b_dout;

    qam_demap_out_buffer u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .tx_done(tx_done), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .buff_full(buff_full), .frame_done(frame_done), .overflow_err(overflow_err)
    );

    qam_demap_out_buffer #(.SYM_BITS(6), .ACTIVE_SUBCARR(4), .SYMBOL_NUM(4), .OUT_BITS(8)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .tx_done(b_tx_done), .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
        .buff_full(b_buff_full), .frame_done(b_frame_done), .overflow_err(b_overflow_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: symbols of the current frame, and the words still owed downstream.
    bit            m_live = 1'b0;
    bit            m_fill = 1'b1;
    bit            m_fd   = 1'b0;
    bit            m_ovf  = 1'b0;
    logic [SB-1:0] m_syms[$];
    logic [OB-1:0] m_words[$];
    int            fd_exp = 0;
    int            fd_dut = 0;

    task automatic model_edge(input bit rst, input bit dv, input logic [SB-1:0] d,
                              input bit dr, input bit txd);
        bit bits[$];
        m_fd = 1'b0;
        if (rst || txd) begin
            m_fill = 1'b1;
            m_ovf  = 1'b0;
            m_syms.delete();
            m_words.delete();
            if (rst) m_live = 1'b1;
        end else if (m_fill) begin
            if (dv) begin
                m_syms.push_back(d);
                if (m_syms.size() == FS) begin
                    foreach (m_syms[i])
                        for (int b = SB - 1; b >= 0; b--) bits.push_back(m_syms[i][b]);
                    for (int w = 0; w < FW; w++) begin
                        logic [OB-1:0] v;
                        v = '0;
                        for (int b = 0; b < OB; b++) v[OB-1-b] = bits[w*OB+b];
                        m_words.push_back(v);
                    end
                    m_syms.delete();
                    m_fill = 1'b0;
                end
            end
        end else begin
            if (dv) m_ovf = 1'b1;
            if (dr) begin
                void'(m_words.pop_front());
                if (m_words.size() == 0) begin
                    m_fill = 1'b1;
                    m_fd   = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit dv, input logic [SB-1:0] d,
                       input bit dr, input bit txd);
        @(negedge clk);
        if (m_live) begin
            check("din_ready", din_ready, m_fill);
            check("dout_valid", dout_valid, !m_fill);
            check("buff_full", buff_full, !m_fill);
            check("dout", dout, m_fill ? 32'd0 : 32'(m_words[0]));
            check("frame_done", frame_done, m_fd);
            check("overflow_err", overflow_err, m_ovf);
            if (m_fd) fd_exp++;
            if (frame_done === 1'b1) fd_dut++;
        end
        rst_n      = !rst;
        din_valid  = dv;
        din        = d;
        dout_ready = dr;
        tx_done    = txd;
        model_edge(rst, dv, d, dr, txd);
    endtask

    initial begin
        int k;
        bit dv;
        bit dr;
        logic [7:0] pat[3];
        pat[0] = 8'hFC;
        pat[1] = 8'h0F;
        pat[2] = 8'hC0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Two back-to-back frames of din = k mod 16; next symbol offered in the frame_done cycle.
        k = 0;
        for (int c = 0; c < 2 * (FS + FW) + 4; c++) begin
            dv = m_fill;
            cyc(0, dv, k[SB-1:0], 1, 0);
            if (dv) k++;
        end

        // Random data, random input gaps, random output back-pressure.
        cyc(0, 0, 0, 1, 1);
        for (int c = 0; c < 1300; c++) begin
            dv = m_fill && ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 1) != 0);
            cyc(0, dv, SB'($urandom), dr, 0);
        end

        // Symbols offered during drain raise the sticky overflow; tx_done clears it.
        cyc(0, 0, 0, 1, 1);
        for (int c = 0; c < 400; c++) begin
            dr = ($urandom_range(0, 2) != 0);
            cyc(0, 1, SB'($urandom), dr, 0);
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // Abort after 100 symbols, then a clean frame.
        for (int c = 0; c < 100; c++) cyc(0, 1, SB'($urandom), 1, 0);
        cyc(0, 0, 0, 1, 1);
        for (int c = 0; c < FS + FW + 3; c++) cyc(0, m_fill, SB'($urandom), 1, 0);

        // tx_done on the last-symbol edge, then on the last-word edge.
        cyc(0, 0, 0, 1, 1);
        for (int c = 0; c < FS - 1; c++) cyc(0, 1, SB'($urandom), 1, 0);
        cyc(0, 1, SB'($urandom), 1, 1);
        cyc(0, 0, 0, 1, 0);
        for (int c = 0; c < FS; c++) cyc(0, 1, SB'($urandom), 1, 0);
        for (int c = 0; c < FW - 1; c++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("frame_done_count", fd_dut, fd_exp);

        // 64-QAM configuration: 6-bit symbols straddle 8-bit words.
        @(negedge clk);
        b_rst_n = 1'b0;
        @(negedge clk);
        check("b_reset_din_ready", b_din_ready, 1);
        check("b_reset_dout_valid", b_dout_valid, 0);
        check("b_reset_dout", b_dout, 0);
        b_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_din       = (i % 2 == 0) ? 6'h3F : 6'h00;
            b_din_valid = 1'b1;
            @(negedge clk);
        end
        b_din_valid  = 1'b0;
        b_dout_ready = 1'b1;
        check("b_dout_valid", b_dout_valid, 1);
        check("b_din_ready", b_din_ready, 0);
        for (int w = 0; w < 5; w++) begin
            check("b_dout", b_dout, pat[w%3]);
            @(negedge clk);
        end
        b_rst_n = 1'b0;
        @(negedge clk);
        check("b_rst_dout", b_dout, 0);
        check("b_rst_dout_valid", b_dout_valid, 0);
        check("b_rst_buff_full", b_buff_full, 0);
        check("b_rst_frame_done", b_frame_done, 0);
        check("b_rst_overflow", b_overflow_err, 0);
        check("b_rst_din_ready", b_din_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
